rx_data_sequencer: RTL and testbench

Receive-side DATA-field sequencer for the 802.11a receiver. Once SIGNAL decoding is complete, it takes the serial scrambled bit stream and recovers the descrambler seed from the first 7 SERVICE bits. It then runs the x^7+x^4+1 descrambler over the rest of the SERVICE field and the PSDU, and counts exactly 8*LENGTH PSDU bits plus the 6 tail bits. It presents only PSDU bits as valid output and signals frame completion to the downstream byte packer.

---
 rtl/rx_data_sequencer.sv | 175 +++++++++++++++++
 tb/tb_rx_data_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_data_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rx_data_sequencer
// Purpose  : 802.11a receive DATA-field sequencer. It recovers the
//            descrambler seed from SERVICE bits 0..6 and descrambles the rest
//            of SERVICE and the PSDU. Only PSDU bits are presented downstream.
//            It counts 8*LENGTH PSDU bits and 6 tail bits, then pulses Done.
// Options  : RX_TAIL_CHECK_EN - when defined, a raw tail bit of 1 sets Error.
// Revision : 1.0 - initial release
// ============================================================================
module rx_data_sequencer #(
  parameter int LENGTH_WIDTH = 12
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [LENGTH_WIDTH-1:0] Length,
  input  logic                    Input,
  input  logic                    InValid,
  output logic                    Output,
  output logic                    OutValid,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);

  localparam int c_CNT_W = 15;
  localparam int c_CMP_W = LENGTH_WIDTH + 3;

`ifdef RX_TAIL_CHECK_EN
  localparam bit c_TAIL_CHECK = 1'b1;
`else
  localparam bit c_TAIL_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_SERVICE = 3'd2,
    ST_PSDU    = 3'd3,
    ST_TAIL    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_CNT_W-1:0]      w_cnt_nxt;
  logic [7:1]              r_lfsr;
  logic [7:1]              w_lfsr_nxt;
  logic [LENGTH_WIDTH-1:0] r_len;
  logic [LENGTH_WIDTH-1:0] w_len_nxt;
  logic                    r_out;
  logic                    w_out_nxt;
  logic                    r_out_valid;
  logic                    w_out_valid_nxt;
  logic                    r_done;
  logic                    w_done_nxt;
  logic                    r_error;
  logic                    w_error_nxt;

  logic                    w_desc_bit;
  logic                    w_data_bit;
  logic [c_CMP_W-1:0]      w_psdu_last;
  logic [c_CMP_W-1:0]      w_cnt_cmp;

  // Descrambler keystream bit, the recovered data bit and the last PSDU index
  // (len is nonzero whenever PSDU is reached, so the subtraction never wraps).
  always_comb begin
    w_desc_bit  = r_lfsr[7] ^ r_lfsr[4];
    w_data_bit  = Input ^ w_desc_bit;
    w_psdu_last = {r_len, 3'b000} - c_CMP_W'(1);
    w_cnt_cmp   = c_CMP_W'(r_cnt);
  end

  // Next-state, counter, LFSR and output decode; Start overrides any input bit.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lfsr_nxt      = r_lfsr;
    w_len_nxt       = r_len;
    w_out_nxt       = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_error_nxt     = r_error;

    if (Start) begin
      w_len_nxt = Length;
      w_cnt_nxt = '0;
      if (Length == '0) begin
        w_error_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_error_nxt = 1'b0;
        w_state_nxt = ST_SEED;
      end
    end else if (InValid) begin
      case (r_state)
        ST_SEED: begin
          // SERVICE bits 0..6 are zero, so received bits are the keystream.
          w_lfsr_nxt = {r_lfsr[6:1], Input};
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(6)) begin
            w_state_nxt = ST_SERVICE;
            w_cnt_nxt   = '0;
          end
        end
        ST_SERVICE: begin
          w_lfsr_nxt = {r_lfsr[6:1], w_desc_bit};
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(8)) begin
            w_state_nxt = ST_PSDU;
            w_cnt_nxt   = '0;
          end
        end
        ST_PSDU: begin
          w_lfsr_nxt      = {r_lfsr[6:1], w_desc_bit};
          w_out_nxt       = w_data_bit;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = r_cnt + 1'b1;
          if (w_cnt_cmp == w_psdu_last) begin
            w_state_nxt = ST_TAIL;
            w_cnt_nxt   = '0;
          end
        end
        ST_TAIL: begin
          // Tail bits are taken raw; the LFSR is left frozen.
          if (c_TAIL_CHECK && Input) begin
            w_error_nxt = 1'b1;
          end
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == c_CNT_W'(5)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          // IDLE: pad bits and stray input are ignored.
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_lfsr      <= 7'b0000000;
      r_len       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_len       <= w_len_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign Output   = r_out;
  assign OutValid = r_out_valid;
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = r_done;
  assign Error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rx_data_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_data_sequencer
// Purpose  : Directed self-checking bench for rx_data_sequencer. Frames are
//            built by a reference x^7+x^4+1 scrambler and compared against
//            hand-computed PSDU bits, Done timing and Error behaviour.
// Options  : RX_TAIL_CHECK_EN - selects the expected Error after a bad tail.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_data_sequencer;

  localparam int LW = 12;

  logic          Clock   = 1'b0;
  logic          Reset   = 1'b0;
  logic          Start   = 1'b0;
  logic [LW-1:0] Length  = '0;
  logic          Input   = 1'b0;
  logic          InValid = 1'b0;
  logic          Output;
  logic          OutValid;
  logic          Busy;
  logic          Done;
  logic          Error;

  rx_data_sequencer #(.LENGTH_WIDTH(LW)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Length   (Length),
    .Input    (Input),
    .InValid  (InValid),
    .Output   (Output),
    .OutValid (OutValid),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error)
  );

  always #5 Clock = ~Clock;

  int n_checks  = 0;
  int n_fails   = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  int first_cyc = 0;
  bit out_q[$];
  bit stream_q[$];

`ifdef RX_TAIL_CHECK_EN
  localparam logic c_TAIL_ERR = 1'b1;
`else
  localparam logic c_TAIL_ERR = 1'b0;
`endif

  // Cycle counter and output monitor, sampled on the falling edge.
  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (OutValid) out_q.push_back(Output);
    if (Done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_bits(input int first, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (first + i < out_q.size()) v[i] = out_q[first + i];
    end
    return v;
  endfunction

  // Reference transmitter: 16 zero SERVICE bits plus PSDU (LSB-first bytes)
  // scrambled from the given seed, followed by 6 raw tail bits.
  task automatic build_stream(input int len, input logic [31:0] data,
                              input logic [6:0] seed, input logic [5:0] tail);
    logic [6:0] s;
    bit         o;
    bit         d;
    stream_q.delete();
    s = seed;
    for (int k = 0; k < 16 + 8 * len; k++) begin
      o = s[6] ^ s[3];
      s = {s[5:0], o};
      d = (k < 16) ? 1'b0 : data[k - 16];
      stream_q.push_back(d ^ o);
    end
    for (int k = 0; k < 6; k++) stream_q.push_back(tail[k]);
  endtask

  task automatic start_frame(input logic [LW-1:0] len);
    Start  = 1'b1;
    Length = len;
    @(posedge Clock); #1;
    Start  = 1'b0;
  endtask

  task automatic send_bits(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      Input   = stream_q[k];
      InValid = 1'b1;
      if (k == 0) first_cyc = cyc;
      @(posedge Clock); #1;
      if (gaps) begin
        InValid = 1'b0;
        @(posedge Clock); #1;
      end
    end
    InValid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) begin
      @(posedge Clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0;
    int d0;

    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_output",   Output,   0);
    check_val("rst_outvalid", OutValid, 0);
    check_val("rst_busy",     Busy,     0);
    check_val("rst_done",     Done,     0);
    check_val("rst_error",    Error,    0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Seed 1011101, zero PSDU, Length=1. Done lands 30 cycles after the
    // first bit's cycle, i.e. in the 31st cycle counting that one as cycle 1.
    build_stream(1, 32'h0, 7'b1011101, 6'b000000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(1);
    check_val("s1_busy_n1", Busy, 1);
    send_bits(30, 1'b0);
    settle();
    check_val("s1_outvalid_cnt", out_q.size() - q0, 8);
    check_val("s1_data",         pack_bits(q0, 8), 32'h0);
    check_val("s1_done_cnt",     done_cnt - d0, 1);
    check_val("s1_done_lat",     done_cyc - first_cyc, 30);
    check_val("s1_busy_end",     Busy, 0);
    check_val("s1_error",        Error, 0);

    // Known data 0xA5, 0x3C from seed 1111111
    build_stream(2, 32'h3CA5, 7'b1111111, 6'b000000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(2);
    send_bits(38, 1'b0);
    settle();
    check_val("kd_outvalid_cnt", out_q.size() - q0, 16);
    check_val("kd_data",         pack_bits(q0, 16), 32'h3CA5);
    check_val("kd_done_cnt",     done_cnt - d0, 1);
    check_val("kd_done_lat",     done_cyc - first_cyc, 38);

    // Length 0: Error next cycle, never busy; the concurrent bit is dropped
    q0 = out_q.size();
    Start = 1'b1; Length = '0; Input = 1'b1; InValid = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check_val("l0_error", Error, 1);
    check_val("l0_busy",  Busy,  0);
    repeat (5) begin
      @(posedge Clock); #1;
    end
    InValid = 1'b0;
    check_val("l0_busy_pad",   Busy, 0);
    check_val("l0_error_hold", Error, 1);
    check_val("l0_no_out",     out_q.size() - q0, 0);

    // Gapped known-data frame; Start also clears the sticky Error
    build_stream(2, 32'h3CA5, 7'b1111111, 6'b000000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(2);
    check_val("gap_error_clr", Error, 0);
    send_bits(38, 1'b1);
    settle();
    check_val("gap_outvalid_cnt", out_q.size() - q0, 16);
    check_val("gap_data",         pack_bits(q0, 16), 32'h3CA5);
    check_val("gap_done_lat",     done_cyc - first_cyc, 75);

    // Abort after PSDU bit 5 of a Length=4 frame, then a full new frame
    build_stream(4, 32'h0000_0096, 7'b0101010, 6'b000000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(4);
    send_bits(7 + 9 + 5, 1'b0);
    check_val("ab_busy_pre", Busy, 1);
    build_stream(2, 32'h3CA5, 7'b0010110, 6'b000000);
    start_frame(2);
    check_val("ab_busy_post", Busy, 1);
    send_bits(38, 1'b0);
    settle();
    check_val("ab_outvalid_cnt", out_q.size() - q0, 21);
    check_val("ab_partial",      pack_bits(q0, 5), 32'h16);
    check_val("ab_new_data",     pack_bits(q0 + 5, 16), 32'h3CA5);
    check_val("ab_done_cnt",     done_cnt - d0, 1);
    check_val("ab_done_lat",     done_cyc - first_cyc, 38);

    // Raw tail bit 3 set
    build_stream(1, 32'h81, 7'b1100011, 6'b001000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(1);
    send_bits(30, 1'b0);
    settle();
    check_val("tc_data",     pack_bits(q0, 8), 32'h81);
    check_val("tc_done_cnt", done_cnt - d0, 1);
    check_val("tc_error",    Error, c_TAIL_ERR);

    // Asynchronous reset in the middle of TAIL
    build_stream(1, 32'h5A, 7'b1010101, 6'b000000);
    q0 = out_q.size(); d0 = done_cnt;
    start_frame(1);
    send_bits(7 + 9 + 8 + 3, 1'b0);
    check_val("rt_busy_pre", Busy, 1);
    check_val("rt_data",     pack_bits(q0, 8), 32'h5A);
    #2;
    Reset = 1'b0;
    #1;
    check_val("rt_busy",     Busy,     0);
    check_val("rt_outvalid", OutValid, 0);
    check_val("rt_output",   Output,   0);
    check_val("rt_done",     Done,     0);
    check_val("rt_error",    Error,    0);
    #2;
    Reset = 1'b1;
    settle();
    check_val("rt_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
